// File: rtl/ac_reg_pkg.sv
// Shared CPU datapath constants. The accumulator and the other datapath
// registers take their word width and clear value from here.
package ac_reg_pkg;

    // Data word width of the CPU datapath.
    localparam int AC_WIDTH = 16;

    // Value a datapath register takes when it is cleared.
    localparam logic [AC_WIDTH-1:0] AC_RST_VAL = 16'h0000;

    // Load-control decode shared by the datapath registers.
    typedef enum logic [1:0] {
        AC_OP_HOLD  = 2'b00,
        AC_OP_LOAD  = 2'b01,
        AC_OP_CLEAR = 2'b10
    } ac_op_e;

    // Resolve the per-edge action. clear is active-low and beats the load
    // enable, so an unknown re or in1 cannot disturb a clear cycle.
    function automatic ac_op_e ac_decode(input logic clear_n, input logic re);
        if (!clear_n) begin
            return AC_OP_CLEAR;
        end else if (re) begin
            return AC_OP_LOAD;
        end else begin
            return AC_OP_HOLD;
        end
    endfunction

endpackage : ac_reg_pkg

// File: rtl/ac_reg_if.sv
// Accumulator data/handshake bundle: load enable and load data towards the
// register, and the registered AC contents back out to the ALU and bus.
interface ac_reg_if
    import ac_reg_pkg::*;
#(
    parameter int WIDTH = AC_WIDTH
);

    logic             re;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out1;

    // Datapath control side: drives load enable and data, reads the AC.
    modport master (
        output re,
        output in1,
        input  out1
    );

    // Register side: samples load enable and data, drives the AC.
    modport slave (
        input  re,
        input  in1,
        output out1
    );

endinterface : ac_reg_if

// File: rtl/ac_reg.sv
// 16-bit accumulator register of the CPU datapath. Synchronous active-low
// clear has priority over load; out1 is the register output with no
// combinational path from any input.
module ac_reg
    import ac_reg_pkg::*;
#(
    parameter int                 WIDTH   = AC_WIDTH,
    parameter logic [WIDTH-1:0]   RST_VAL = AC_RST_VAL
) (
    input  logic        clk,
    input  logic        clear,
    ac_reg_if.slave     bus
);

    logic [WIDTH-1:0] r_ac;

    // Accumulator state: clear beats load, otherwise hold. An unknown re
    // during clear is harmless because the clear branch is taken first.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_ac <= RST_VAL;
        end else if (bus.re) begin
            r_ac <= bus.in1;
        end
    end

    assign bus.out1 = r_ac;

`ifndef SYNTHESIS
    // Simulation-only checks; armed after the first clear so the undefined
    // power-up contents are not checked.
    logic r_armed;

    // Record that at least one clear edge has been seen.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_armed <= 1'b1;
        end else if (r_armed !== 1'b1) begin
            r_armed <= 1'b0;
        end
    end

    a_clear_value: assert property (@(posedge clk) (clear === 1'b0) |=> (bus.out1 == RST_VAL));

    a_hold_stable: assert property (@(posedge clk)
        (r_armed === 1'b1 && clear === 1'b1 && bus.re === 1'b0) |=> $stable(bus.out1));
`endif

endmodule : ac_reg

// File: tb/tb_ac_reg.sv
// Directed, table-driven bench for the accumulator register.
module tb_ac_reg;
    import ac_reg_pkg::*;

    logic clk;
    logic clear;

    ac_reg_if #(.WIDTH(AC_WIDTH)) bus ();

    ac_reg #(
        .WIDTH   (AC_WIDTH),
        .RST_VAL (AC_RST_VAL)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clear;
        logic        re;
        logic [15:0] in1;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out1=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic r, input logic [15:0] d, input logic [15:0] e);
        vec_t v;
        v.clear = c;
        v.re    = r;
        v.in1   = d;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    logic [15:0] prev_exp;
    logic [15:0] mid_vals[3];

    initial begin
        // Reset: clear beats re
        add(1'b0, 1'b1, 16'hBEEF, 16'h0000);
        add(1'b0, 1'b1, 16'hBEEF, 16'h0000);
        // Load
        add(1'b1, 1'b1, 16'h1234, 16'h1234);
        // Hold with toggling data
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b0, (i % 2 == 0) ? 16'hFFFF : 16'h0001, 16'h1234);
        // Back-to-back loads
        add(1'b1, 1'b1, 16'h0001, 16'h0001);
        add(1'b1, 1'b1, 16'h8000, 16'h8000);
        add(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        // Mid-operation clear then immediate resume
        add(1'b1, 1'b1, 16'hA5A5, 16'hA5A5);
        add(1'b0, 1'b1, 16'h5A5A, 16'h0000);
        add(1'b1, 1'b1, 16'h5A5A, 16'h5A5A);
        // Unknown re/in1 during clear, then hold with unknown data
        add(1'b0, 1'bx, 16'hxxxx, 16'h0000);
        add(1'b1, 1'b0, 16'hxxxx, 16'h0000);
        add(1'b1, 1'b1, 16'hC3C3, 16'hC3C3);

        clear   = 1'b0;
        bus.re  = 1'b0;
        bus.in1 = 16'h0000;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear   = vecs[i].clear;
            bus.re  = vecs[i].re;
            bus.in1 = vecs[i].in1;
            #1;
            // New inputs must not reach out1 before the edge
            if (i > 0) check($sformatf("pre_edge[%0d]", i), bus.out1, prev_exp);
            @(posedge clk);
            #1;
            $display("vec %0d: clear=%b re=%b in1=%h out1=%h exp=%h",
                     i, vecs[i].clear, vecs[i].re, vecs[i].in1, bus.out1, vecs[i].exp);
            check($sformatf("vec[%0d]", i), bus.out1, vecs[i].exp);
            prev_exp = vecs[i].exp;
        end

        // Comb isolation: wiggle in1 with re=1 between edges
        mid_vals[0] = 16'h1111;
        mid_vals[1] = 16'h2222;
        mid_vals[2] = 16'h7E57;
        @(negedge clk);
        clear  = 1'b1;
        bus.re = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in1 = mid_vals[k];
            #1;
            $display("iso %0d: in1=%h out1=%h exp=%h", k, bus.in1, bus.out1, 16'hC3C3);
            check($sformatf("iso_mid[%0d]", k), bus.out1, 16'hC3C3);
        end
        @(posedge clk);
        #1;
        $display("iso edge: out1=%h exp=%h", bus.out1, 16'h7E57);
        check("iso_edge", bus.out1, 16'h7E57);

        // Stable across the whole following cycle with re dropped
        @(negedge clk);
        bus.re  = 1'b0;
        bus.in1 = 16'h0000;
        #3;
        check("stable_mid", bus.out1, 16'h7E57);
        @(posedge clk);
        #1;
        $display("hold edge: out1=%h exp=%h", bus.out1, 16'h7E57);
        check("stable_hold", bus.out1, 16'h7E57);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ac_reg
